extensor: RTL and testbench

- Immediate-extension unit of the MIPS decode stage.
- Takes the fetched 32-bit instruction and registers several extended forms of its fields:
  - the sign-extended 16-bit immediate, used as the branch offset;
  - the branch byte offset (sign-extended immediate shifted left by 2);
  - an opcode-selected ALU immediate (sign-, zero- or LUI-extended);
  - the zero-extended shift amount.
- Outputs feed the branch adder and the ALU operand mux.

---
 rtl/extensor.sv | 87 ++++++++
 tb/tb_extensor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/extensor.sv
// Immediate-extension unit for the decode stage: registers the sign-extended
// branch offset, its byte form, an opcode-selected ALU immediate and the
// zero-extended shift amount of the fetched instruction.
module extensor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMM_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    output logic [DATA_WIDTH-1:0] o_branchoffset,
    output logic [DATA_WIDTH-1:0] o_branchbyteoff,
    output logic [DATA_WIDTH-1:0] o_aluimm,
    output logic [DATA_WIDTH-1:0] o_shamt,
    output logic                  o_zeroext_sel
);

    localparam int unsigned FillWidth = DATA_WIDTH - IMM_WIDTH;

    localparam logic [5:0] OpAndi = 6'h0C;
    localparam logic [5:0] OpOri  = 6'h0D;
    localparam logic [5:0] OpXori = 6'h0E;
    localparam logic [5:0] OpLui  = 6'h0F;

    logic [IMM_WIDTH-1:0]  imm;
    logic [5:0]            op;
    logic                  unused_instr;

    logic [DATA_WIDTH-1:0] branchoffset_d, branchoffset_q;
    logic [DATA_WIDTH-1:0] branchbyteoff_d, branchbyteoff_q;
    logic [DATA_WIDTH-1:0] aluimm_d, aluimm_q;
    logic [DATA_WIDTH-1:0] shamt_d, shamt_q;
    logic                  zeroext_sel_d, zeroext_sel_q;

    assign imm = i_instruccion[IMM_WIDTH-1:0];
    assign op  = i_instruccion[DATA_WIDTH-1 -: 6];

    // Bits between the opcode and the immediate (rs/rt) are not needed here.
    assign unused_instr = ^i_instruccion;

    // Extended forms of the current instruction, ready to be captured.
    always_comb begin
        branchoffset_d  = {{FillWidth{imm[IMM_WIDTH-1]}}, imm};
        // Byte offset drops the top two bits; no saturation.
        branchbyteoff_d = {branchoffset_d[DATA_WIDTH-3:0], 2'b00};
        shamt_d         = {{(DATA_WIDTH - 5){1'b0}}, i_instruccion[10:6]};
        aluimm_d        = branchoffset_d;
        zeroext_sel_d   = 1'b0;
        case (op)
            OpAndi, OpOri, OpXori: begin
                aluimm_d      = {{FillWidth{1'b0}}, imm};
                zeroext_sel_d = 1'b1;
            end
            OpLui: begin
                aluimm_d = {imm, {FillWidth{1'b0}}};
            end
            default: begin
                aluimm_d = branchoffset_d;
            end
        endcase
    end

    // Output registers: clear asynchronously, capture when enabled, else hold.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            branchoffset_q  <= '0;
            branchbyteoff_q <= '0;
            aluimm_q        <= '0;
            shamt_q         <= '0;
            zeroext_sel_q   <= 1'b0;
        end else if (i_enable) begin
            branchoffset_q  <= branchoffset_d;
            branchbyteoff_q <= branchbyteoff_d;
            aluimm_q        <= aluimm_d;
            shamt_q         <= shamt_d;
            zeroext_sel_q   <= zeroext_sel_d;
        end
    end

    assign o_branchoffset  = branchoffset_q;
    assign o_branchbyteoff = branchbyteoff_q;
    assign o_aluimm        = aluimm_q;
    assign o_shamt         = shamt_q;
    assign o_zeroext_sel   = zeroext_sel_q;

endmodule

// File: tb/tb_extensor.sv
// Self-checking bench for extensor: directed cases plus randomized
// instructions against an arithmetic reference model.
module tb_extensor;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] ins;
    logic [31:0] bo, bbo, alu, sh;
    logic        zs;
    logic [128:0] outs;

    int nvec = 0;
    int nerr = 0;

    extensor #(
        .DATA_WIDTH(32),
        .IMM_WIDTH (16)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_enable       (en),
        .i_instruccion  (ins),
        .o_branchoffset (bo),
        .o_branchbyteoff(bbo),
        .o_aluimm       (alu),
        .o_shamt        (sh),
        .o_zeroext_sel  (zs)
    );

    assign outs = {bo, bbo, alu, sh, zs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: offsets as two's-complement integers, ALU immediate by opcode class.
    function automatic logic [128:0] model(input logic [31:0] w);
        logic [31:0] imm, off, boff, aimm, samt;
        logic        zsel;
        int unsigned op;
        imm  = w & 32'hFFFF;
        op   = w >> 26;
        off  = (imm >= 32'h8000) ? imm - 32'h10000 : imm;
        boff = off * 4;
        samt = (w >> 6) % 32;
        if (op == 12 || op == 13 || op == 14) begin
            aimm = imm;
            zsel = 1'b1;
        end else if (op == 15) begin
            aimm = imm * 65536;
            zsel = 1'b0;
        end else begin
            aimm = off;
            zsel = 1'b0;
        end
        return {off, boff, aimm, samt, zsel};
    endfunction

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] w);
        ins = w;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        ins = 32'h3C00FFFF;
        #2;
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL reset_async: got %h required 0", outs);
        end
        tick();
        tick();
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL reset_held: got %h required 0", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL reset_release: got %h required 0", outs);
        end
    endtask

    task automatic test_sign();
        logic [128:0] exp;
        apply(32'h00009240);
        exp = {32'hFFFF9240, 32'hFFFE4900, 32'hFFFF9240, 32'd9, 1'b0};
        nvec++;
        if (outs !== exp) begin
            nerr++;
            $display("FAIL sign_negative: got %h required %h", outs, exp);
        end
        apply(32'h00001240);
        exp = {32'h00001240, 32'h00004900, 32'h00001240, 32'd9, 1'b0};
        nvec++;
        if (outs !== exp) begin
            nerr++;
            $display("FAIL sign_positive: got %h required %h", outs, exp);
        end
    endtask

    task automatic test_opcode();
        logic [128:0] exp;
        apply(32'h34009240);
        exp = {32'hFFFF9240, 32'hFFFE4900, 32'h00009240, 32'd9, 1'b1};
        nvec++;
        if (outs !== exp) begin
            nerr++;
            $display("FAIL opcode_ori: got %h required %h", outs, exp);
        end
        apply(32'h3C009240);
        exp = {32'hFFFF9240, 32'hFFFE4900, 32'h92400000, 32'd9, 1'b0};
        nvec++;
        if (outs !== exp) begin
            nerr++;
            $display("FAIL opcode_lui: got %h required %h", outs, exp);
        end
        apply(32'h30009240);
        nvec++;
        if (alu !== 32'h00009240 || zs !== 1'b1) begin
            nerr++;
            $display("FAIL opcode_andi: got %h/%b required 00009240/1", alu, zs);
        end
        apply(32'h38009240);
        nvec++;
        if (alu !== 32'h00009240 || zs !== 1'b1) begin
            nerr++;
            $display("FAIL opcode_xori: got %h/%b required 00009240/1", alu, zs);
        end
        apply(32'h20009240);
        nvec++;
        if (alu !== 32'hFFFF9240 || zs !== 1'b0) begin
            nerr++;
            $display("FAIL opcode_addi: got %h/%b required ffff9240/0", alu, zs);
        end
    endtask

    task automatic test_boundaries();
        apply(32'h00008000);
        nvec++;
        if (bo !== 32'hFFFF8000 || bbo !== 32'hFFFE0000) begin
            nerr++;
            $display("FAIL bound_8000: got %h %h required ffff8000 fffe0000", bo, bbo);
        end
        apply(32'h00007FFF);
        nvec++;
        if (bo !== 32'h00007FFF || bbo !== 32'h0001FFFC) begin
            nerr++;
            $display("FAIL bound_7fff: got %h %h required 00007fff 0001fffc", bo, bbo);
        end
        apply(32'h0000FFFF);
        nvec++;
        if (bo !== 32'hFFFFFFFF || bbo !== 32'hFFFFFFFC) begin
            nerr++;
            $display("FAIL bound_ffff: got %h %h required ffffffff fffffffc", bo, bbo);
        end
        apply(32'h000007C0);
        nvec++;
        if (sh !== 32'd31) begin
            nerr++;
            $display("FAIL shamt_max: got %h required 0000001f", sh);
        end
    endtask

    task automatic test_stall();
        logic [128:0] held, fresh;
        held  = {32'hFFFF9240, 32'hFFFE4900, 32'hFFFF9240, 32'd9, 1'b0};
        fresh = {32'h00001240, 32'h00004900, 32'h00001240, 32'd9, 1'b0};
        apply(32'h00009240);
        en  = 1'b0;
        ins = 32'h00001240;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (outs !== held) begin
                nerr++;
                $display("FAIL stall_hold%0d: got %h required %h", i, outs, held);
            end
        end
        en = 1'b1;
        tick();
        nvec++;
        if (outs !== fresh) begin
            nerr++;
            $display("FAIL stall_resume: got %h required %h", outs, fresh);
        end
    endtask

    task automatic test_async_reset();
        logic [128:0] exp;
        apply(32'h3400FFFF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL async_clear: got %h required 0", outs);
        end
        tick();
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL async_held: got %h required 0", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        ins = 32'h00009240;
        #1;
        nvec++;
        if (outs !== 129'd0) begin
            nerr++;
            $display("FAIL async_release: got %h required 0", outs);
        end
        tick();
        exp = model(32'h00009240);
        nvec++;
        if (outs !== exp) begin
            nerr++;
            $display("FAIL async_recapture: got %h required %h", outs, exp);
        end
    endtask

    task automatic test_random();
        logic [128:0] exp;
        logic [31:0]  w;
        logic [5:0]   ops [6] = '{6'h00, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
        exp = outs === model(32'h00009240) ? model(32'h00009240) : 129'd0;
        exp = model(32'h00009240);
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(1) == 1) w[31:26] = ops[$urandom_range(5)];
            en  = ($urandom_range(3) != 0);
            ins = w;
            if (en) exp = model(w);
            tick();
            nvec++;
            if (outs !== exp) begin
                nerr++;
                $display("FAIL random%0d ins=%h en=%b: got %h required %h",
                         i, w, en, outs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sign();
        test_opcode();
        test_boundaries();
        test_stall();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
